alu_input_sequencer: RTL and testbench
======================================

Name: alu_input_sequencer

Overview:
- Parametrised successor to the board-level ALU front end: takes switch data and three push-buttons, and latches operand A, operand B and the operation code.
- Adds synchronisation, debounce and one-shot edge detection per button.
- Adds a load-tracking FSM that qualifies the result, an internal NB_DATA-wide ALU with a registered result, and an invalid-opcode flag.
- Sits between the board I/O (switches, buttons, LEDs) and the rest of the design.

Parameters:
- NB_DATA, 8, operand/result width; also the switch count.
- NB_OP, 6, opcode width, taken from I_sw[NB_OP-1:0]; requires NB_OP <= NB_DATA.
- N_BUTTONS, 3, button count; fixed at 3: [0]=A, [1]=B, [2]=OP.
- DEBOUNCE_CYCLES, 4, consecutive stable cycles required to accept a level change; must be >= 1.
- NB_CNT, 20, debounce counter width; requires 2^NB_CNT > DEBOUNCE_CYCLES.

Ports:
- I_clk  input  1  system clock; every register is rising-edge.
- I_reset_n  input  1  synchronous, active-low reset.
- I_sw  input  NB_DATA  switch value, loaded on a button event.
- I_button  input  N_BUTTONS  raw asynchronous buttons, active-high.
- O_result  output  NB_DATA  registered ALU result.
- O_overflow  output  1  registered signed overflow (ADD/SUB only).
- O_zero  output  1  registered; 1 when O_result == 0.
- O_op_err  output  1  registered; 1 when the latched opcode is unsupported.
- O_valid  output  1  registered; 1 while state == READY.
- O_loaded  output  3  sticky load mask {OP,B,A}.

Behaviour:
- Reset: I_reset_n sampled low at an edge clears all registers: sync flops, debounced levels, counters, A, B, OP, mask, state=EMPTY, and all outputs to 0. Reset mid-debounce or mid-operation abandons everything; no load occurs from a press already in progress.
- Per-button path:
  - Two-flop synchroniser, giving s2.
  - Counter cnt: cleared when s2 == deb; otherwise incremented.
  - When s2 != deb and cnt == DEBOUNCE_CYCLES-1, deb <= s2 and cnt <= 0.
  - load pulse = deb rising (0->1), registered, exactly one cycle per accepted press. Release also needs DEBOUNCE_CYCLES stable cycles.
- Latency: I_button[i] held high from edge t gives load pulse high during cycle t+DEBOUNCE_CYCLES+2. The operand/opcode register updates at the following edge. O_result reflects the new operand one edge after that.
- Loads:
  - A <= I_sw on pulse[0]; B <= I_sw on pulse[1]; OP <= I_sw[NB_OP-1:0] on pulse[2].
  - Simultaneous pulses are all honoured in the same cycle with the same I_sw.
  - Each pulse sets its O_loaded bit; bits stay set until reset.
- FSM:
  - EMPTY -> PARTIAL when any load occurs but the mask is not complete.
  - EMPTY or PARTIAL -> READY on the cycle the mask becomes 3'b111 (including all three at once).
  - READY is terminal until reset. Reloads in READY are allowed and stay in READY.
- Result register:
  - In READY, {O_result, O_overflow, O_zero, O_op_err} are recomputed every edge from the current A/B/OP registers.
  - Outside READY, they are held at 0, except O_zero=0.
  - O_valid <= (next_state == READY), so it rises on the same edge as the first valid result.
- ALU (A and B are two's-complement):
  - 100000 ADD: A+B wraps mod 2^NB_DATA; overflow = operand signs equal and result sign differs.
  - 100010 SUB: A-B wraps; overflow = operand signs differ and result sign != sign of A.
  - 100100 AND; 100101 OR; 100110 XOR; 100111 NOR.
  - 000011 SRA: A >>> B, with B unsigned; B >= NB_DATA gives all copies of the sign bit.
  - 000010 SRL: A >> B; B >= NB_DATA gives 0.
  - Other opcodes: result 0, O_op_err=1, O_overflow=0, O_zero=1.
  - O_overflow is 0 for every opcode except ADD/SUB.
- Glitches: a pulse shorter than DEBOUNCE_CYCLES cycles after synchronisation produces no load. Holding a button produces exactly one load.

Test Plan:
- Reset then idle 20 cycles -> all outputs 0, O_valid=0, O_loaded=000.
- Sequence (DEBOUNCE_CYCLES=4): sw=0x7F press A, sw=0x01 press B, sw=0x20 press OP (ADD), each held 10 cycles:
  - O_loaded steps 001, 011, 111.
  - O_valid rises on the edge after the OP load.
  - O_result=0x80, O_overflow=1, O_zero=0.
- In READY, load B=0x7F then OP=100010 (SUB) with A=0x7F -> O_result=0x00, O_zero=1, O_overflow=0, O_valid stays 1.
- A=0x80, B=0x09, OP=000011 -> result 0xFF. OP=000010 -> 0x00. B=0x01 with SRA -> 0xC0.
- Glitch: 3-cycle button pulse -> no load. Held 200 cycles -> exactly one load pulse. All three buttons pressed together with sw=0x25 -> A=B=0x25, OP=100101, state EMPTY->READY directly, result 0x25.
- OP=111111 -> O_op_err=1, O_result=0, O_zero=1. Reset asserted mid-debounce -> no load after release, state EMPTY.

Source files
------------

// File: rtl/alu_input_sequencer_if.sv
// Board-side bundle for the ALU input sequencer: switch/button inputs and
// the registered ALU result, overflow/zero/error, valid and load-mask outputs.
interface alu_input_sequencer_if #(
  parameter int NB_DATA   = 8,
  parameter int N_BUTTONS = 3
);
  logic [NB_DATA-1:0]   I_sw;
  logic [N_BUTTONS-1:0] I_button;
  logic [NB_DATA-1:0]   O_result;
  logic                 O_overflow;
  logic                 O_zero;
  logic                 O_op_err;
  logic                 O_valid;
  logic [2:0]           O_loaded;

  modport master (
    output I_sw, I_button,
    input  O_result, O_overflow, O_zero, O_op_err, O_valid, O_loaded
  );

  modport slave (
    input  I_sw, I_button,
    output O_result, O_overflow, O_zero, O_op_err, O_valid, O_loaded
  );
endinterface

// File: rtl/alu_input_sequencer.sv
// Board-level ALU front end: debounced one-shot buttons load operand A, operand B
// and the opcode from the switches; a registered ALU result is produced once all three are loaded.
module alu_input_sequencer #(
  parameter int NB_DATA         = 8,
  parameter int NB_OP           = 6,
  parameter int N_BUTTONS       = 3,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int NB_CNT          = 20
) (
  input logic              I_clk,
  input logic              I_reset_n,
  alu_input_sequencer_if.slave bus
);

  localparam logic [NB_CNT-1:0]  CNT_LAST    = NB_CNT'(DEBOUNCE_CYCLES - 1);
  localparam logic [NB_DATA:0]   SHIFT_LIMIT = (NB_DATA + 1)'(NB_DATA);

  localparam logic [NB_OP-1:0] OP_ADD = NB_OP'(6'b100000);
  localparam logic [NB_OP-1:0] OP_SUB = NB_OP'(6'b100010);
  localparam logic [NB_OP-1:0] OP_AND = NB_OP'(6'b100100);
  localparam logic [NB_OP-1:0] OP_OR  = NB_OP'(6'b100101);
  localparam logic [NB_OP-1:0] OP_XOR = NB_OP'(6'b100110);
  localparam logic [NB_OP-1:0] OP_NOR = NB_OP'(6'b100111);
  localparam logic [NB_OP-1:0] OP_SRA = NB_OP'(6'b000011);
  localparam logic [NB_OP-1:0] OP_SRL = NB_OP'(6'b000010);

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PARTIAL = 2'd1,
    READY   = 2'd2
  } state_t;

  state_t state_q;
  state_t state_next;

  logic [N_BUTTONS-1:0] sync1_q;
  logic [N_BUTTONS-1:0] sync2_q;
  logic [N_BUTTONS-1:0] deb_q;
  logic [N_BUTTONS-1:0] deb_d_q;
  logic [N_BUTTONS-1:0] pulse_q;
  logic [NB_CNT-1:0]    cnt_q [N_BUTTONS];

  logic [NB_DATA-1:0] a_q;
  logic [NB_DATA-1:0] b_q;
  logic [NB_OP-1:0]   op_q;
  logic [2:0]         loaded_q;

  logic [NB_DATA-1:0] alu_res;
  logic               alu_ovf;
  logic               alu_err;
  logic               alu_zero;
  logic               shift_big;
  logic               ready_next;

  logic [NB_DATA-1:0] result_q;
  logic               overflow_q;
  logic               zero_q;
  logic               op_err_q;
  logic               valid_q;

  // A level change is accepted only after it has been seen for DEBOUNCE_CYCLES
  // consecutive synchronised cycles; the load pulse marks the accepted press.
  always_ff @(posedge I_clk) begin
    if (!I_reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      deb_q   <= '0;
      deb_d_q <= '0;
      pulse_q <= '0;
      for (int i = 0; i < N_BUTTONS; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q <= bus.I_button;
      sync2_q <= sync1_q;
      deb_d_q <= deb_q;
      pulse_q <= deb_q & ~deb_d_q;
      for (int i = 0; i < N_BUTTONS; i++) begin
        if (sync2_q[i] == deb_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          deb_q[i] <= sync2_q[i];
          cnt_q[i] <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge I_clk) begin
    if (!I_reset_n) begin
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      loaded_q <= '0;
    end else begin
      if (pulse_q[0]) a_q  <= bus.I_sw;
      if (pulse_q[1]) b_q  <= bus.I_sw;
      if (pulse_q[2]) op_q <= bus.I_sw[NB_OP-1:0];
      loaded_q <= loaded_q | pulse_q[2:0];
    end
  end

  always_ff @(posedge I_clk) begin
    if (!I_reset_n) state_q <= EMPTY;
    else            state_q <= state_next;
  end

  // READY follows the registered mask, so the first result uses the freshly loaded operands.
  always_comb begin
    state_next = state_q;
    case (state_q)
      EMPTY: begin
        if (loaded_q == 3'b111)    state_next = READY;
        else if (loaded_q != 3'b0) state_next = PARTIAL;
      end
      PARTIAL: begin
        if (loaded_q == 3'b111) state_next = READY;
      end
      READY:   state_next = READY;
      default: state_next = EMPTY;
    endcase
  end

  always_comb begin
    shift_big = ({1'b0, b_q} >= SHIFT_LIMIT);
    alu_res   = '0;
    alu_ovf   = 1'b0;
    alu_err   = 1'b0;
    case (op_q)
      OP_ADD: begin
        alu_res = a_q + b_q;
        alu_ovf = (a_q[NB_DATA-1] == b_q[NB_DATA-1]) && (alu_res[NB_DATA-1] != a_q[NB_DATA-1]);
      end
      OP_SUB: begin
        alu_res = a_q - b_q;
        alu_ovf = (a_q[NB_DATA-1] != b_q[NB_DATA-1]) && (alu_res[NB_DATA-1] != a_q[NB_DATA-1]);
      end
      OP_AND: alu_res = a_q & b_q;
      OP_OR:  alu_res = a_q | b_q;
      OP_XOR: alu_res = a_q ^ b_q;
      OP_NOR: alu_res = ~(a_q | b_q);
      OP_SRA: begin
        if (shift_big) alu_res = {NB_DATA{a_q[NB_DATA-1]}};
        else           alu_res = $unsigned($signed(a_q) >>> b_q);
      end
      OP_SRL: begin
        if (shift_big) alu_res = '0;
        else           alu_res = a_q >> b_q;
      end
      default: alu_err = 1'b1;
    endcase
    alu_zero   = (alu_res == '0);
    ready_next = (state_next == READY);
  end

  // Outside READY every result flag is forced low, including zero.
  always_ff @(posedge I_clk) begin
    if (!I_reset_n) begin
      result_q   <= '0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
      op_err_q   <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      valid_q <= ready_next;
      if (ready_next) begin
        result_q   <= alu_res;
        overflow_q <= alu_ovf;
        zero_q     <= alu_zero;
        op_err_q   <= alu_err;
      end else begin
        result_q   <= '0;
        overflow_q <= 1'b0;
        zero_q     <= 1'b0;
        op_err_q   <= 1'b0;
      end
    end
  end

  assign bus.O_result   = result_q;
  assign bus.O_overflow = overflow_q;
  assign bus.O_zero     = zero_q;
  assign bus.O_op_err   = op_err_q;
  assign bus.O_valid    = valid_q;
  assign bus.O_loaded   = loaded_q;

endmodule

// File: tb/tb_alu_input_sequencer.sv
// Directed and randomized bench for alu_input_sequencer against a
// press-level operand/opcode model with an arithmetic ALU reference.
module tb_alu_input_sequencer;

  localparam int NB_DATA = 8;
  localparam int NB_OP   = 6;
  localparam int NBTN    = 3;
  localparam int DEB     = 4;

  logic clk = 1'b0;
  logic reset_n;

  always #5 clk = ~clk;

  alu_input_sequencer_if #(.NB_DATA(NB_DATA), .N_BUTTONS(NBTN)) bus ();

  alu_input_sequencer #(
    .NB_DATA(NB_DATA), .NB_OP(NB_OP), .N_BUTTONS(NBTN),
    .DEBOUNCE_CYCLES(DEB), .NB_CNT(20)
  ) dut (
    .I_clk(clk),
    .I_reset_n(reset_n),
    .bus(bus)
  );

  int checks = 0;
  int fails  = 0;

  logic [7:0] mA, mB;
  logic [5:0] mOp;
  logic [2:0] mMask;
  int kLoaded, kValid;

  logic [5:0] opTable [9] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                              6'b100110, 6'b100111, 6'b000011, 6'b000010, 6'b111111};

  // Reference ALU in plain integer arithmetic: returns {result, overflow, zero, err}.
  function automatic logic [10:0] refAlu(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    int sa, sb, r;
    logic [7:0] res;
    logic ovf, err;
    sa = int'($signed(a));
    sb = int'($signed(b));
    res = 8'h00;
    ovf = 1'b0;
    err = 1'b0;
    case (op)
      6'b100000: begin r = sa + sb; ovf = (r > 127) || (r < -128); res = r[7:0]; end
      6'b100010: begin r = sa - sb; ovf = (r > 127) || (r < -128); res = r[7:0]; end
      6'b100100: res = a & b;
      6'b100101: res = a | b;
      6'b100110: res = a ^ b;
      6'b100111: res = ~(a | b);
      6'b000011: begin r = sa >>> ((b > 8'd31) ? 31 : int'(b)); res = r[7:0]; end
      6'b000010: res = (b >= 8'd8) ? 8'h00 : (a >> b);
      default:   err = 1'b1;
    endcase
    return {res, ovf, (res == 8'h00), err};
  endfunction

  task automatic checkEq(input string name, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", name, observed, expected);
    end
  endtask

  task automatic checkOutput(input string tag);
    logic [10:0] e;
    logic        rdy;
    rdy = (mMask == 3'b111);
    e   = rdy ? refAlu(mA, mB, mOp) : 11'd0;
    checkEq({tag, ".result"},   bus.O_result,   e[10:3]);
    checkEq({tag, ".overflow"}, bus.O_overflow, e[2]);
    checkEq({tag, ".zero"},     bus.O_zero,     e[1]);
    checkEq({tag, ".op_err"},   bus.O_op_err,   e[0]);
    checkEq({tag, ".valid"},    bus.O_valid,    rdy);
    checkEq({tag, ".loaded"},   bus.O_loaded,   mMask);
  endtask

  // Holds the buttons for 'hold' sampling edges, then waits out the release debounce.
  // Records the first cycle O_loaded changes and the first cycle O_valid rises.
  task automatic applyStimulus(input logic [7:0] sw, input logic [2:0] btn, input int hold, input bit swapSw);
    logic [2:0] prevLoaded;
    logic       prevValid;
    @(negedge clk);
    bus.I_sw     = sw;
    bus.I_button = btn;
    prevLoaded   = bus.O_loaded;
    prevValid    = bus.O_valid;
    kLoaded      = -1;
    kValid       = -1;
    for (int k = 1; k <= hold + DEB + 12; k++) begin
      @(negedge clk);
      if (k == hold) bus.I_button = 3'b000;
      if (swapSw && k == DEB + 6) bus.I_sw = ~sw;
      if (kLoaded < 0 && bus.O_loaded !== prevLoaded) kLoaded = k;
      if (kValid < 0 && bus.O_valid === 1'b1 && prevValid !== 1'b1) kValid = k;
    end
    if (hold >= DEB) begin
      if (btn[0]) mA  = sw;
      if (btn[1]) mB  = sw;
      if (btn[2]) mOp = sw[5:0];
      mMask = mMask | btn;
    end
  endtask

  task automatic doReset(input int cycles);
    @(negedge clk);
    reset_n      = 1'b0;
    bus.I_button = 3'b000;
    repeat (cycles) @(negedge clk);
    reset_n = 1'b1;
    mA = 8'h00; mB = 8'h00; mOp = 6'h00; mMask = 3'b000;
  endtask

  initial begin
    logic [7:0] rsw;
    logic [2:0] rbtn;
    int         rhold;

    bus.I_sw     = 8'h00;
    bus.I_button = 3'b000;
    reset_n      = 1'b0;
    mA = 8'h00; mB = 8'h00; mOp = 6'h00; mMask = 3'b000;
    doReset(3);
    repeat (20) @(negedge clk);
    checkOutput("idle");

    applyStimulus(8'h7F, 3'b001, 10, 1'b0);
    checkEq("latencyA", kLoaded, DEB + 4);
    checkOutput("loadA");
    applyStimulus(8'h01, 3'b010, 10, 1'b0);
    checkOutput("loadB");
    applyStimulus(8'h20, 3'b100, 10, 1'b0);
    checkEq("validAfterOp", kValid, kLoaded + 1);
    checkEq("addResult", bus.O_result, 8'h80);
    checkEq("addOverflow", bus.O_overflow, 1'b1);
    checkOutput("add");

    applyStimulus(8'h7F, 3'b010, 10, 1'b0);
    applyStimulus(8'h22, 3'b100, 10, 1'b0);
    checkEq("subZero", bus.O_zero, 1'b1);
    checkOutput("sub");

    applyStimulus(8'h80, 3'b001, 10, 1'b0);
    applyStimulus(8'h09, 3'b010, 10, 1'b0);
    applyStimulus(8'h03, 3'b100, 10, 1'b0);
    checkEq("sraBig", bus.O_result, 8'hFF);
    checkOutput("sraBig");
    applyStimulus(8'h02, 3'b100, 10, 1'b0);
    checkOutput("srlBig");
    applyStimulus(8'h03, 3'b100, 10, 1'b0);
    applyStimulus(8'h01, 3'b010, 10, 1'b0);
    checkEq("sra1", bus.O_result, 8'hC0);
    checkOutput("sra1");

    applyStimulus(8'h55, 3'b001, 3, 1'b0);
    checkOutput("glitch");
    applyStimulus(8'h12, 3'b001, 200, 1'b1);
    checkOutput("hold200");

    doReset(2);
    repeat (5) @(negedge clk);
    applyStimulus(8'h25, 3'b111, 10, 1'b0);
    checkEq("allThreeValid", kValid, kLoaded + 1);
    checkEq("allThreeResult", bus.O_result, 8'h25);
    checkOutput("allThree");

    applyStimulus(8'h3F, 3'b100, 10, 1'b0);
    checkEq("opErr", bus.O_op_err, 1'b1);
    checkOutput("badOp");

    @(negedge clk);
    bus.I_sw     = 8'hAA;
    bus.I_button = 3'b001;
    repeat (3) @(negedge clk);
    doReset(2);
    repeat (20) @(negedge clk);
    checkOutput("resetMidDebounce");

    for (int n = 0; n < 30; n++) begin
      rbtn  = 3'($urandom_range(1, 7));
      rhold = $urandom_range(1, 12);
      rsw   = 8'($urandom);
      if ($urandom_range(0, 1) == 1) rsw = {rsw[7:6], opTable[$urandom_range(0, 8)]};
      applyStimulus(rsw, rbtn, rhold, 1'b0);
      checkOutput("random");
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
